// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the parametrised Fibonacci/Lucas engine.
//   state_t      : controller states (IDLE, CALC, DONE)
//   MODE_*       : request mode encoding (0 = Fibonacci, 1 = Lucas)
//   *_S0 / *_S1  : the two seed terms of each recurrence
// ---------------------------------------------------------------------------
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FIB   = 1'b0;
    localparam logic MODE_LUCAS = 1'b1;

    localparam int FIB_S0 = 0;
    localparam int FIB_S1 = 1;
    localparam int LUC_S0 = 2;
    localparam int LUC_S1 = 1;

endpackage

// File: rtl/fib_datapath.sv
// ---------------------------------------------------------------------------
// fib_datapath
// Holds the two running terms of the recurrence, the WIDTH+1-bit adder and
// the per-term overflow tracking.
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : seed the terms for i_mode and clear overflow tracking
//   i_step       : advance the recurrence by one term
//   i_mode       : 0 = Fibonacci seeds, 1 = Lucas seeds
//   o_a          : current term (low WIDTH bits)
//   o_ovfA       : the true value of the current term exceeds WIDTH bits
// ---------------------------------------------------------------------------
module fib_datapath
    import fib_pkg::*;
#(
    parameter int WIDTH = 121
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a,
    output logic             o_ovfA
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ovfA;
    logic             r_ovfB;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_seed0;
    logic [WIDTH-1:0] w_seed1;

    // The sum is one bit wider than the terms so its top bit is the carry
    // out of the modulo-2^WIDTH addition.
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Seed selection; seeds are truncated to WIDTH bits like every term.
    always_comb begin
        w_seed0 = WIDTH'(FIB_S0);
        w_seed1 = WIDTH'(FIB_S1);
        if (i_mode == MODE_LUCAS) begin
            w_seed0 = WIDTH'(LUC_S0);
            w_seed1 = WIDTH'(LUC_S1);
        end
    end

    // Overflow is tracked separately for each term, so a carry that only
    // affects the look-ahead term b never marks the reported term a.
    // Once a term has wrapped, every later term is also wrapped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_ovfA <= 1'b0;
            r_ovfB <= 1'b0;
        end else if (i_load) begin
            r_a    <= w_seed0;
            r_b    <= w_seed1;
            r_ovfA <= 1'b0;
            r_ovfB <= 1'b0;
        end else if (i_step) begin
            r_a    <= r_b;
            r_b    <= w_sum[WIDTH-1:0];
            r_ovfA <= r_ovfB;
            r_ovfB <= r_ovfA | r_ovfB | w_sum[WIDTH];
        end
    end

    assign o_a    = r_a;
    assign o_ovfA = r_ovfA;

endmodule

// File: rtl/fib_engine_param.sv
// ---------------------------------------------------------------------------
// fib_engine_param
// Computes the n-th Fibonacci or Lucas term modulo 2^WIDTH behind a
// start/done handshake.
//   clk       : clock
//   reset     : synchronous active-high reset
//   start     : request pulse, accepted only in IDLE or DONE
//   n         : term index, latched on an accepted start
//   mode      : 0 = Fibonacci, 1 = Lucas, latched on an accepted start
//   ans       : term value mod 2^WIDTH, valid while done is high
//   done      : result valid, held until the next accepted start or reset
//   busy      : high while computing
//   overflow  : true term value does not fit in WIDTH bits
// ---------------------------------------------------------------------------
module fib_engine_param
    import fib_pkg::*;
#(
    parameter int WIDTH = 121,
    parameter int N_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic             mode,
    output logic [WIDTH-1:0] ans,
    output logic             done,
    output logic             busy,
    output logic             overflow
);

    state_t           r_state;
    logic [N_W-1:0]   r_cnt;
    logic [WIDTH-1:0] r_ans;
    logic             r_done;
    logic             r_busy;
    logic             r_ovf;

    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_a;
    logic             w_ovfA;

    // A start is only honoured when no computation is in flight; the
    // recurrence advances on every CALC cycle until the counter runs out.
    assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_step = (r_state == CALC) && (r_cnt != '0);

    fib_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_mode (mode),
        .o_a    (w_a),
        .o_ovfA (w_ovfA)
    );

    // Controller: n steps are taken, then one more cycle copies the current
    // term to the output, so done rises n+1 edges after the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ans   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_cnt   <= n;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == '0) begin
                        r_ans   <= w_a;
                        r_ovf   <= w_ovfA;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - N_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ans      = r_ans;
    assign done     = r_done;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fib_engine_param.sv
// ---------------------------------------------------------------------------
// tb_fib_engine_param
// Self-checking bench for fib_engine_param at default parameters and at
// WIDTH=8, using a vector table, hand-written corner sequences and random
// requests compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fib_engine_param;

    logic         clk = 1'b0;
    logic         reset;

    logic         start;
    logic [4:0]   n;
    logic         mode;
    logic [120:0] ans;
    logic         done;
    logic         busy;
    logic         overflow;

    logic         start8;
    logic [4:0]   n8;
    logic         mode8;
    logic [7:0]   ans8;
    logic         done8;
    logic         busy8;
    logic         overflow8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           m;
        int           nv;
        logic [127:0] expAns;
        bit           expOvf;
    } vec_t;

    vec_t vecs[15];

    fib_engine_param dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .mode     (mode),
        .ans      (ans),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    fib_engine_param #(
        .WIDTH (8),
        .N_W   (5)
    ) dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .n        (n8),
        .mode     (mode8),
        .ans      (ans8),
        .done     (done8),
        .busy     (busy8),
        .overflow (overflow8)
    );

    // Free-running 10 ns clock shared by both instances.
    always #5 clk = ~clk;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the recurrence with exact 64-bit arithmetic (terms up
    // to index 31 fit easily), then reduce to the requested width.
    function automatic void refTerm(input bit m, input int nv, input int w,
                                    output logic [127:0] ansOut, output bit ovfOut);
        longint unsigned x, y, t;
        x = m ? 64'd2 : 64'd0;
        y = 64'd1;
        for (int i = 0; i < nv; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        if (w < 64) begin
            ovfOut = (x >> w) != 0;
            ansOut = 128'(x & ((64'd1 << w) - 64'd1));
        end else begin
            ovfOut = 1'b0;
            ansOut = 128'(x);
        end
    endfunction

    // One full request: start on the accepting edge, scramble n/mode while
    // computing, then measure latency and check the result.
    task automatic applyStimulus(input bit use8, input bit m, input int nv,
                                 input logic [127:0] expAns, input bit expOvf, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        if (use8) begin
            start8 = 1'b1; mode8 = m; n8 = nv[4:0];
        end else begin
            start = 1'b1; mode = m; n = nv[4:0];
        end
        @(posedge clk);
        #1;
        start = 1'b0; start8 = 1'b0;
        n = ~n; mode = ~mode; n8 = ~n8; mode8 = ~mode8;
        checkOutput({tag, " done-low"}, 128'(use8 ? done8 : done), 128'd0);
        checkOutput({tag, " busy-high"}, 128'(use8 ? busy8 : busy), 128'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            seen = use8 ? done8 : done;
        end
        checkOutput({tag, " done-seen"}, 128'(seen), 128'd1);
        checkOutput({tag, " latency"}, 128'(lat), 128'(nv + 1));
        checkOutput({tag, " ans"}, use8 ? 128'(ans8) : 128'(ans), expAns);
        checkOutput({tag, " overflow"}, 128'(use8 ? overflow8 : overflow), 128'(expOvf));
        checkOutput({tag, " busy-low"}, 128'(use8 ? busy8 : busy), 128'd0);
    endtask

    initial begin
        logic [127:0] ea;
        bit           eo;
        int           lat;
        bit           busyBad;
        bit           seen;

        vecs[0]  = '{0, 10, 128'd55, 0};
        vecs[1]  = '{0, 0,  128'd0, 0};
        vecs[2]  = '{1, 5,  128'd11, 0};
        vecs[3]  = '{1, 0,  128'd2, 0};
        vecs[4]  = '{0, 31, 128'd1346269, 0};
        vecs[5]  = '{0, 1,  128'd1, 0};
        vecs[6]  = '{0, 2,  128'd1, 0};
        vecs[7]  = '{0, 5,  128'd5, 0};
        vecs[8]  = '{0, 15, 128'd610, 0};
        vecs[9]  = '{0, 20, 128'd6765, 0};
        vecs[10] = '{0, 25, 128'd75025, 0};
        vecs[11] = '{1, 1,  128'd1, 0};
        vecs[12] = '{1, 2,  128'd3, 0};
        vecs[13] = '{1, 10, 128'd123, 0};
        vecs[14] = '{1, 31, 128'd3010349, 0};

        reset = 1'b1;
        start = 1'b0; n = '0; mode = 1'b0;
        start8 = 1'b0; n8 = '0; mode8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ans", 128'(ans), 128'd0);
        checkOutput("reset done", 128'(done), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset overflow", 128'(overflow), 128'd0);
        checkOutput("reset8 done", 128'(done8), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Default-width vector file.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, vecs[i].m, vecs[i].nv, vecs[i].expAns, vecs[i].expOvf,
                          $sformatf("vec%0d", i));
        end

        // Narrow instance: F13 fits while its look-ahead term carries; F14 wraps.
        applyStimulus(1'b1, 1'b0, 13, 128'd233, 1'b0, "w8 F13");
        applyStimulus(1'b1, 1'b0, 14, 128'd121, 1'b1, "w8 F14");

        // A second start three cycles into an n=20 run must be ignored.
        @(negedge clk);
        start = 1'b1; n = 5'd20; mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyBad = !busy;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            if (lat == 3) begin
                @(negedge clk);
                start = 1'b1; n = 5'd3; mode = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            seen = done;
            if (!seen && !busy) busyBad = 1'b1;
        end
        checkOutput("ignore-start done-seen", 128'(seen), 128'd1);
        checkOutput("ignore-start latency", 128'(lat), 128'd21);
        checkOutput("ignore-start ans", 128'(ans), 128'd6765);
        checkOutput("ignore-start busy-held", 128'(busyBad), 128'd0);

        // Reset mid-computation discards the run and clears every output.
        @(negedge clk);
        start = 1'b1; n = 5'd20; mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-reset ans", 128'(ans), 128'd0);
        checkOutput("mid-reset done", 128'(done), 128'd0);
        checkOutput("mid-reset busy", 128'(busy), 128'd0);
        checkOutput("mid-reset overflow", 128'(overflow), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 7, 128'd13, 1'b0, "after-reset F7");

        // Restart straight from DONE.
        applyStimulus(1'b0, 1'b0, 10, 128'd55, 1'b0, "pre-restart F10");
        applyStimulus(1'b0, 1'b1, 6, 128'd18, 1'b0, "restart L6");

        // Random requests on both widths against the reference model.
        for (int i = 0; i < 30; i++) begin
            bit use8;
            bit m;
            int nv;
            use8 = 1'($urandom_range(0, 1));
            m    = 1'($urandom_range(0, 1));
            nv   = int'($urandom_range(0, 31));
            refTerm(m, nv, use8 ? 8 : 121, ea, eo);
            applyStimulus(use8, m, nv, ea, eo,
                          $sformatf("rand%0d w%0d m%0d n%0d", i, use8 ? 8 : 121, m, nv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_engine_param.md
Name: fib_engine_param

Overview:
- Parametrised successor to the fixed 5-bit-index, 121-bit Fibonacci calculator.
- Computes the n-th term of a two-seed additive recurrence: Fibonacci (seeds 0,1) or Lucas (seeds 2,1), selected per request.
- Adds a busy flag, a sticky overflow flag, restart-from-done and a configurable result width.
- Sits behind the same start/done handshake, so existing test-vector benches drive it unchanged at default parameters.

Parameters:
- WIDTH, 121, result width in bits; arithmetic is modulo 2^WIDTH.
- N_W, 5, width of the index input n.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising edge of clk.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- n  input  N_W  term index; latched on accepted start.
- mode  input  1  0 = Fibonacci, 1 = Lucas; latched on accepted start.
- ans  output  WIDTH  term value mod 2^WIDTH; valid while done=1.
- done  output  1  result valid, held until next accepted start or reset.
- busy  output  1  high while computing.
- overflow  output  1  true term value ≥ 2^WIDTH; valid while done=1.

Behaviour:
- Reset values: ans=0, done=0, busy=0, overflow=0, state=IDLE. All internal registers (a, b, cnt, ovf_a, ovf_b) are 0.
- Reset has priority over every other event, including mid-computation; any in-flight result is discarded.
- States:
  - IDLE: start=1 -> load, go CALC.
  - CALC: iterate.
  - DONE: outputs held; start=1 -> load, go CALC.
- Load, on the accepted edge k:
  - a <= seed0, b <= seed1 (Fib 0,1; Lucas 2,1).
  - cnt <= n; ovf_a <= 0; ovf_b <= 0.
  - busy <= 1, done <= 0.
- CALC, each edge:
  - If cnt==0: ans <= a, overflow <= ovf_a, done <= 1, busy <= 0, go DONE.
  - Else: a <= b; b <= (a+b) mod 2^WIDTH; cnt <= cnt-1; ovf_a <= ovf_b; ovf_b <= ovf_a | ovf_b | carry(a+b).
- Latency: done rises on edge k+n+1; n=0 gives 1 cycle. Maximum is 2^N_W cycles.
- start during CALC is ignored; n and mode changes during CALC are ignored.
- A start held high continuously in DONE restarts every completion. The bench pulses start for 1–3 cycles; a re-accept after completion is intended.
- The addition is computed WIDTH+1 bits wide; bit WIDTH is the carry.
- Overflow is tracked per register, so a carry in the unused look-ahead term b never flags the result.
- Wrap-around is silent apart from the overflow flag: ans holds the low WIDTH bits.
- n = 2^N_W - 1 is legal.

Decomposition:
- Package fib_pkg holds:
  - the state encoding (IDLE, CALC, DONE);
  - mode constants MODE_FIB=0, MODE_LUCAS=1;
  - seed constants FIB_S0=0, FIB_S1=1, LUC_S0=2, LUC_S1=1.
- One sub-module, fib_datapath (WIDTH), holds the a/b registers, the adder with carry, and the ovf_a/ovf_b tracking. It is driven by load/step enables from the FSM in fib_engine_param.

Test Plan:
- Default params: mode=0, n=10 -> done on 11th edge after start, ans=55, overflow=0. Then mode=0, n=0 -> done after 1 edge, ans=0.
- Default params: mode=1, n=5 -> ans=11; mode=1, n=0 -> ans=2; mode=0, n=31 -> ans=1346269, done after 32 edges.
- WIDTH=8, mode=0: n=13 -> ans=233, overflow=0 (look-ahead carry ignored). n=14 -> ans=121, overflow=1.
- start pulsed again 3 cycles into an n=20 run -> ignored; result F20=6765 at original latency, busy high throughout.
- reset asserted mid-CALC for 1 cycle -> next edge all outputs 0, IDLE; new start with n=7 -> ans=13.
- In DONE with ans=55, start with n=6, mode=1 -> done drops next edge, ans=18 after 7 edges. Replay the full 15-vector default file -> 0 errors.
